// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control codes and execute-stage FSM encodings.
//                Also consumed by the ALU control decoder for MUL decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU control codes produced by the decoder
  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_SLT = 4'b0111;
  localparam logic [3:0] C_ALU_NOR = 4'b1100;
  localparam logic [3:0] C_ALU_MUL = 4'b1000;

  // Execute-stage FSM states
  localparam logic [0:0] C_ST_IDLE = 1'b0;
  localparam logic [0:0] C_ST_MUL  = 1'b1;

  // True when the control code selects the iterative multiplier
  function automatic logic is_mul_op(input logic [3:0] ctl);
    return (ctl == C_ALU_MUL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Iterative shift-add multiplier, one bit of b per clock.
//                Returns the low W bits of a*b after W cycles. done_o is
//                high during the final iteration, and product_o then
//                carries the completed product for capture on that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] product_o
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt_q,    cnt_d;
  logic [W-1:0]  acc_q,    acc_d;
  logic [W-1:0]  mcand_q,  mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [W-1:0]  w_acc_next;

  // Accumulator value after the current iteration's conditional add
  assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign busy_o    = (cnt_q != '0);
  assign done_o    = (cnt_q == CW'(1));
  assign product_o = w_acc_next;

  // Load operands on start, otherwise iterate while the counter is non-zero
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      cnt_d    = CW'(W);
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CW'(1);
      acc_d    = w_acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // Iteration registers; reset aborts any multiply in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec
//  Description : Execute stage. Single-cycle AND/OR/ADD/SUB/SLT/NOR with a
//                registered result, zero and signed-overflow flag; MUL is
//                handed to an iterative multiplier. Valid/ready on both the
//                input and output side.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_ctl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         ovf
);

  logic [0:0]   state_q,     state_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] result_q,    result_d;
  logic         zero_q,      zero_d;
  logic         ovf_q,       ovf_d;

  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_alu_res;
  logic         w_alu_ovf;
  logic         w_accept;
  logic         w_mul_start;
  logic         w_mul_busy;
  logic         w_mul_done;
  logic [W-1:0] w_mul_prod;

  assign w_sum  = a + b;
  assign w_diff = a - b;

  // A held result may be drained and replaced on the same edge
  assign in_ready = (state_q == C_ST_IDLE) && !w_mul_busy && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

  // Single-cycle ALU; unknown codes (and MUL here) yield 0 with no overflow
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (alu_ctl)
      C_ALU_AND: w_alu_res = a & b;
      C_ALU_OR:  w_alu_res = a | b;
      C_ALU_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      C_ALU_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);
      end
      C_ALU_SLT: w_alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      C_ALU_NOR: w_alu_res = ~(a | b);
      default:   w_alu_res = '0;
    endcase
  end

  // FSM and output-register next state
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    w_mul_start = 1'b0;
    if (state_q == C_ST_IDLE) begin
      if (w_accept) begin
        if (is_mul_op(alu_ctl)) begin
          // Accept implies any held result is drained this edge
          w_mul_start = 1'b1;
          state_d     = C_ST_MUL;
          out_valid_d = 1'b0;
        end else begin
          result_d    = w_alu_res;
          zero_d      = (w_alu_res == '0);
          ovf_d       = w_alu_ovf;
          out_valid_d = 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (w_mul_done) begin
        result_d    = w_mul_prod;
        zero_d      = (w_mul_prod == '0);
        ovf_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = C_ST_IDLE;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= C_ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  alu_mul_seq #(
    .W (W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (w_mul_start),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (w_mul_busy),
    .done_o    (w_mul_done),
    .product_o (w_mul_prod)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec
//  Description : Directed self-checking bench for alu_exec (W = 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec;

  localparam int W = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_UND = 4'b0011;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_ctl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; samples happen 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    in_valid = v;
    alu_ctl  = op;
    a        = va;
    b        = vb;
  endtask

  initial begin
    int bad;
    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_ctl   = 4'b0000;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    #1;
    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    result,         32'h0);
    chk("rst_zero",      32'(zero),      32'd1);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    tick();
    tick();
    rst = 1'b0;

    // ADD overflow
    drive(1'b1, OP_ADD, 32'h7fffffff, 32'h1);
    tick();
    chk("add_ovf_valid",  32'(out_valid), 32'd1);
    chk("add_ovf_result", result,         32'h80000000);
    chk("add_ovf_ovf",    32'(ovf),       32'd1);
    chk("add_ovf_zero",   32'(zero),      32'd0);

    // SUB to zero (drain and refill on the same edge)
    drive(1'b1, OP_SUB, 32'h5, 32'h5);
    tick();
    chk("sub_zero_result", result,         32'h0);
    chk("sub_zero_zero",   32'(zero),      32'd1);
    chk("sub_zero_ovf",    32'(ovf),       32'd0);
    chk("sub_zero_valid",  32'(out_valid), 32'd1);

    // SUB overflow: most-negative minus one
    drive(1'b1, OP_SUB, 32'h80000000, 32'h1);
    tick();
    chk("sub_ovf_result", result,   32'h7fffffff);
    chk("sub_ovf_ovf",    32'(ovf), 32'd1);

    // SLT signed: -1 < 1, then 1 < -1
    drive(1'b1, OP_SLT, 32'hffffffff, 32'h1);
    tick();
    chk("slt_neg_result", result, 32'h1);
    drive(1'b1, OP_SLT, 32'h1, 32'hffffffff);
    tick();
    chk("slt_pos_result", result,     32'h0);
    chk("slt_pos_zero",   32'(zero),  32'd1);

    // NOR, AND, OR
    drive(1'b1, OP_NOR, 32'h0, 32'h0);
    tick();
    chk("nor_result", result,    32'hffffffff);
    chk("nor_zero",   32'(zero), 32'd0);
    drive(1'b1, OP_AND, 32'hf0f0ff00, 32'h0ff0f0f0);
    tick();
    chk("and_result", result, 32'h00f0f000);
    drive(1'b1, OP_OR, 32'hf0f0ff00, 32'h0ff0f0f0);
    tick();
    chk("or_result", result, 32'hfff0fff0);

    // Undefined code
    drive(1'b1, OP_UND, 32'h5, 32'h7);
    tick();
    chk("und_result", result,         32'h0);
    chk("und_zero",   32'(zero),      32'd1);
    chk("und_ovf",    32'(ovf),       32'd0);
    chk("und_valid",  32'(out_valid), 32'd1);

    // Idle input: result consumed, out_valid drops
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // MUL 3*5: accept at edge k, result valid after edge k+32
    drive(1'b1, OP_MUL, 32'h3, 32'h5);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    chk("mul_acc_in_ready", 32'(in_ready), 32'd0);
    bad = 0;
    for (int i = 1; i < W; i++) begin
      tick();
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    chk("mul_busy_window", 32'(bad), 32'd0);
    tick();
    chk("mul_valid",  32'(out_valid), 32'd1);
    chk("mul_result", result,         32'd15);
    chk("mul_ovf",    32'(ovf),       32'd0);
    chk("mul_zero",   32'(zero),      32'd0);
    tick();
    chk("mul_drain", 32'(out_valid), 32'd0);

    // MUL wrap: 0x10000 * 0x10000 -> low word 0
    drive(1'b1, OP_MUL, 32'h00010000, 32'h00010000);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    for (int i = 0; i < W; i++) tick();
    chk("mulw_valid",  32'(out_valid), 32'd1);
    chk("mulw_result", result,         32'h0);
    chk("mulw_zero",   32'(zero),      32'd1);

    // MUL all-ones squared -> low word 1
    drive(1'b1, OP_MUL, 32'hffffffff, 32'hffffffff);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    for (int i = 0; i < W; i++) tick();
    chk("mulf_result", result, 32'h1);
    tick();

    // Back-pressure: second ADD held off until drain
    drive(1'b1, OP_ADD, 32'h1, 32'h2);
    tick();
    chk("bp_first_result", result, 32'h3);
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'ha, 32'h14);
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold1_result", result,         32'h3);
    chk("bp_hold1_valid",  32'(out_valid), 32'd1);
    tick();
    chk("bp_hold2_result", result,         32'h3);
    chk("bp_hold2_ready",  32'(in_ready),  32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 32'(in_ready), 32'd1);
    tick();
    chk("bp_second_result", result,         32'h1e);
    chk("bp_second_valid",  32'(out_valid), 32'd1);
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    tick();
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // Reset during MUL (cycle 10 of 32)
    drive(1'b1, OP_MUL, 32'h3, 32'h5);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready",  32'(in_ready),  32'd1);
    chk("mrst_result",    result,         32'h0);
    chk("mrst_zero",      32'(zero),      32'd1);
    #1;
    rst = 1'b0;
    drive(1'b1, OP_ADD, 32'h2, 32'h2);
    tick();
    chk("mrst_add_result", result,         32'h4);
    chk("mrst_add_valid",  32'(out_valid), 32'd1);
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    // An aborted MUL must not surface later
    bad = 0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("mrst_no_ghost", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
